// File: rtl/cpu_debug_pkg.sv
// Shared constants and state encodings for the
// run-control debug controller.
package cpu_debug_pkg;

    localparam logic [7:0] OP_HALT   = 8'h01;
    localparam logic [7:0] OP_RESUME = 8'h02;
    localparam logic [7:0] OP_STEP   = 8'h03;
    localparam logic [7:0] OP_SETBP  = 8'h04;
    localparam logic [7:0] OP_CLRBP  = 8'h05;
    localparam logic [7:0] OP_READPC = 8'h06;
    localparam logic [7:0] OP_STATUS = 8'h07;

    localparam logic [7:0] RSP_OK  = 8'h00;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    typedef enum logic [1:0] {
        RS_RUN    = 2'd0,
        RS_STEP   = 2'd1,
        RS_HALTED = 2'd2
    } run_state_e;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_ARG  = 2'd1,
        P_RSP  = 2'd2
    } parse_state_e;

endpackage

// File: rtl/cpu_debug_ctl_if.sv
// Host debug link: command byte channel in,
// response byte channel out.
interface cpu_debug_ctl_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;

    modport master (
        output cmd_valid, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/cpu_debug_rsp_ser.sv
// Response serializer: loads up to NB bytes plus a
// count, shifts them out LSB first on valid/ready.
module cpu_debug_rsp_ser #(
    parameter  int NB = 4,
    localparam int CW = $clog2(NB + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [NB*8-1:0] load_data,
    input  logic [CW-1:0]   load_cnt,
    input  logic            rsp_ready,
    output logic            rsp_valid,
    output logic [7:0]      rsp_data,
    output logic            last_xfer
);

    logic [NB*8-1:0] buf_q;
    logic [CW-1:0]   cnt_q;
    logic            xfer;

    assign rsp_valid = (cnt_q != '0);
    assign rsp_data  = buf_q[7:0];
    assign xfer      = rsp_valid && rsp_ready;
    assign last_xfer = xfer && (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            buf_q <= load_data;
            cnt_q <= load_cnt;
        end else if (xfer) begin
            buf_q <= buf_q >> 8;
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/cpu_debug_ctl.sv
// Run-control debug controller: host command parser plus
// RUN/STEP/HALTED FSM driving the pipeline stall.
module cpu_debug_ctl
    import cpu_debug_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    cpu_debug_ctl_if.slave  link,
    input  logic            retire_4a,
    input  logic [PC_W-1:0] pc_4a,
    output logic            dbg_stall,
    output logic            halted
);

    localparam int NB = PC_W / 8;
    localparam int CW = $clog2(NB + 1);
    localparam int AW = (NB > 1) ? $clog2(NB) : 1;
    localparam run_state_e RS_INIT =
        RESET_HALTED ? RS_HALTED : RS_RUN;

    parse_state_e    p_q, p_d;
    run_state_e      rs_q, rs_d;
    logic [AW-1:0]   arg_cnt_q;
    logic [PC_W-1:0] arg_q, arg_nx;
    logic [PC_W-1:0] bp_addr_q, halt_pc_q;
    logic            bp_en_q, skip_q;

    logic            cmd_acc, is_halted, bp_hit;
    logic            go_halt, go_resume, go_step;
    logic            set_bp, clr_bp;
    logic            ld, last_xfer;
    logic [PC_W-1:0] ld_data;
    logic [CW-1:0]   ld_cnt;

    assign link.cmd_ready = (p_q != P_RSP);
    assign cmd_acc   = link.cmd_valid && link.cmd_ready;
    assign is_halted = (rs_q == RS_HALTED);
    assign halted    = is_halted;

    // Address bytes arrive LSB first; shift each in from the top.
    assign arg_nx = (arg_q >> 8)
                  | (PC_W'(link.cmd_data) << (PC_W - 8));

    assign bp_hit = retire_4a && bp_en_q && !skip_q
                 && (pc_4a == bp_addr_q) && !is_halted;

    always_comb begin
        p_d       = p_q;
        ld        = 1'b0;
        ld_data   = PC_W'(RSP_OK);
        ld_cnt    = CW'(1);
        go_halt   = 1'b0;
        go_resume = 1'b0;
        go_step   = 1'b0;
        set_bp    = 1'b0;
        clr_bp    = 1'b0;
        unique case (p_q)
            P_IDLE: if (cmd_acc) begin
                ld  = 1'b1;
                p_d = P_RSP;
                case (link.cmd_data)
                    OP_HALT:   go_halt = 1'b1;
                    OP_RESUME: begin
                        if (is_halted) go_resume = 1'b1;
                        else ld_data = PC_W'(RSP_ERR);
                    end
                    OP_STEP: begin
                        if (is_halted) go_step = 1'b1;
                        else ld_data = PC_W'(RSP_ERR);
                    end
                    OP_SETBP: begin
                        ld  = 1'b0;
                        p_d = P_ARG;
                    end
                    OP_CLRBP:  clr_bp = 1'b1;
                    OP_READPC: begin
                        ld_data = halt_pc_q;
                        ld_cnt  = CW'(NB);
                    end
                    OP_STATUS:
                        ld_data = PC_W'({5'b0, bp_en_q, rs_q});
                    default: ld_data = PC_W'(RSP_ERR);
                endcase
            end
            P_ARG: if (cmd_acc && arg_cnt_q == AW'(NB - 1)) begin
                set_bp = 1'b1;
                ld     = 1'b1;
                p_d    = P_RSP;
            end
            P_RSP: if (last_xfer) p_d = P_IDLE;
            default: p_d = P_IDLE;
        endcase
    end

    always_comb begin
        rs_d = rs_q;
        if (is_halted) begin
            if (go_resume)    rs_d = RS_RUN;
            else if (go_step) rs_d = RS_STEP;
        end else if (go_halt || bp_hit
                  || (rs_q == RS_STEP && retire_4a)) begin
            rs_d = RS_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q       <= P_IDLE;
            rs_q      <= RS_INIT;
            dbg_stall <= RESET_HALTED;
            arg_cnt_q <= '0;
            arg_q     <= '0;
            bp_en_q   <= 1'b0;
            bp_addr_q <= '0;
            halt_pc_q <= '0;
            skip_q    <= 1'b0;
        end else begin
            p_q       <= p_d;
            rs_q      <= rs_d;
            dbg_stall <= (rs_d == RS_HALTED);
            if (p_q != P_ARG) begin
                arg_cnt_q <= '0;
            end else if (cmd_acc) begin
                arg_cnt_q <= arg_cnt_q + 1'b1;
                arg_q     <= arg_nx;
            end
            if (set_bp) begin
                bp_addr_q <= arg_nx;
                bp_en_q   <= 1'b1;
            end else if (clr_bp) begin
                bp_en_q   <= 1'b0;
            end
            if (retire_4a) halt_pc_q <= pc_4a;
            // A fresh RESUME/STEP wins over a straggler retiring now.
            if (go_resume || go_step) skip_q <= 1'b1;
            else if (retire_4a)       skip_q <= 1'b0;
        end
    end

    cpu_debug_rsp_ser #(.NB(NB)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ld),
        .load_data (ld_data),
        .load_cnt  (ld_cnt),
        .rsp_ready (link.rsp_ready),
        .rsp_valid (link.rsp_valid),
        .rsp_data  (link.rsp_data),
        .last_xfer (last_xfer)
    );

endmodule

// File: tb/tb_cpu_debug_ctl.sv
// Bench for cpu_debug_ctl: directed plan plus random
// traffic against a byte-queue reference model.
module tb_cpu_debug_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        retire_4a = 1'b0;
    logic [31:0] pc_4a = '0;
    logic        dbg_stall, halted;

    cpu_debug_ctl_if link();

    cpu_debug_ctl #(.PC_W(32), .RESET_HALTED(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .link      (link),
        .retire_4a (retire_4a),
        .pc_4a     (pc_4a),
        .dbg_stall (dbg_stall),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    // Reference model: run state 0=RUN 1=STEP 2=HALTED,
    // host phase 0=opcode 1=args 2=responding.
    int          m_st, m_phase, m_argi;
    bit          m_bp_en, m_skip;
    logic [31:0] m_bp_addr, m_halt_pc, m_arg;
    logic [7:0]  rsp_q[$];
    logic [7:0]  host_q[$];

    task automatic m_reset();
        m_st = 0; m_phase = 0; m_argi = 0;
        m_bp_en = 0; m_skip = 0;
        m_bp_addr = '0; m_halt_pc = '0; m_arg = '0;
        rsp_q.delete();
        host_q.delete();
    endtask

    task automatic tick(input bit v, input bit ret,
                        input logic [31:0] pc,
                        input bit rdy, input bit r);
        bit acc, racc, hit, hlt, res, stp;
        logic [7:0] b;
        @(negedge clk);
        check("cmd_ready", link.cmd_ready, m_phase != 2);
        check("rsp_valid", link.rsp_valid, rsp_q.size() != 0);
        if (rsp_q.size() != 0)
            check("rsp_data", link.rsp_data, rsp_q[0]);
        check("halted", halted, m_st == 2);
        check("dbg_stall", dbg_stall, m_st == 2);
        rst = r;
        link.cmd_valid = v && host_q.size() != 0;
        link.cmd_data = host_q.size() != 0 ? host_q[0]
                                           : 8'($urandom);
        link.rsp_ready = rdy;
        retire_4a = ret;
        pc_4a = pc;
        if (r) begin
            m_reset();
            return;
        end
        acc  = link.cmd_valid && m_phase != 2;
        racc = rdy && rsp_q.size() != 0;
        b    = link.cmd_data;
        hit  = ret && m_bp_en && !m_skip
            && pc == m_bp_addr && m_st != 2;
        hlt = 0; res = 0; stp = 0;
        if (racc) begin
            void'(rsp_q.pop_front());
            if (rsp_q.size() == 0) m_phase = 0;
        end
        if (acc) begin
            void'(host_q.pop_front());
            if (m_phase == 0) begin
                case (b)
                    8'h01: begin hlt = 1; rsp_q.push_back(8'h00); end
                    8'h02: if (m_st == 2) begin
                        res = 1; rsp_q.push_back(8'h00);
                    end else rsp_q.push_back(8'hEE);
                    8'h03: if (m_st == 2) begin
                        stp = 1; rsp_q.push_back(8'h00);
                    end else rsp_q.push_back(8'hEE);
                    8'h04: begin m_argi = 0; m_arg = '0; end
                    8'h05: begin m_bp_en = 0; rsp_q.push_back(8'h00); end
                    8'h06: for (int i = 0; i < 4; i++)
                        rsp_q.push_back(m_halt_pc[8*i +: 8]);
                    8'h07: rsp_q.push_back({5'b0, m_bp_en, 2'(m_st)});
                    default: rsp_q.push_back(8'hEE);
                endcase
                m_phase = (b == 8'h04) ? 1 : 2;
            end else if (m_phase == 1) begin
                m_arg[8*m_argi +: 8] = b;
                m_argi++;
                if (m_argi == 4) begin
                    m_bp_en = 1;
                    m_bp_addr = m_arg;
                    rsp_q.push_back(8'h00);
                    m_phase = 2;
                end
            end
        end
        if (m_st == 2) begin
            if (res) m_st = 0;
            else if (stp) m_st = 1;
        end else if (hlt || hit || (m_st == 1 && ret)) begin
            m_st = 2;
        end
        if (res || stp) m_skip = 1;
        else if (ret) m_skip = 0;
        if (ret) m_halt_pc = pc;
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while ((host_q.size() != 0 || rsp_q.size() != 0
                || m_phase != 0) && n < 200) begin
            tick(1, 0, 0, rnd ? ($urandom_range(0, 3) != 0) : 1'b1, 0);
            n++;
        end
        check("drain_bound", n < 200, 1);
    endtask

    task automatic send(input logic [7:0] op);
        host_q.push_back(op);
        drain(0);
    endtask

    task automatic send_bp(input logic [31:0] a);
        host_q.push_back(8'h04);
        for (int i = 0; i < 4; i++) host_q.push_back(a[8*i +: 8]);
        drain(0);
    endtask

    task automatic rand_cmd();
        logic [31:0] a;
        a = 32'h10 + 32'(4 * $urandom_range(0, 3));
        case ($urandom_range(0, 8))
            0, 8: host_q.push_back(8'h01);
            1: host_q.push_back(8'h02);
            2: host_q.push_back(8'h03);
            3: begin
                host_q.push_back(8'h04);
                for (int i = 0; i < 4; i++) host_q.push_back(a[8*i +: 8]);
            end
            4: host_q.push_back(8'h05);
            5: host_q.push_back(8'h06);
            6: host_q.push_back(8'h07);
            default: host_q.push_back(8'($urandom_range(8, 255)));
        endcase
    endtask

    initial begin
        link.cmd_valid = 1'b0;
        link.cmd_data  = '0;
        link.rsp_ready = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        check("rst_rsp_data", link.rsp_data, 8'h00);

        send(8'h01);
        send(8'h07);
        send(8'h02);
        send_bp(32'h10);
        tick(0, 1, 32'h10, 1, 0);
        tick(0, 0, 0, 1, 0);
        send(8'h06);
        send(8'h07);
        send(8'h03);
        tick(0, 1, 32'h10, 1, 0);
        tick(0, 0, 0, 1, 0);
        send(8'h03);
        tick(0, 0, 0, 1, 0);
        tick(0, 1, 32'h14, 1, 0);
        tick(0, 0, 0, 1, 0);
        send(8'h02);
        send(8'h03);
        send(8'h55);
        send(8'h01);
        tick(0, 1, 32'h1234_5678, 1, 0);
        host_q.push_back(8'h06);
        for (int i = 0; i < 7; i++) tick(1, 0, 0, 0, 0);
        drain(0);

        send(8'h02);
        host_q.push_back(8'h04);
        host_q.push_back(8'h20);
        host_q.push_back(8'h30);
        for (int i = 0; i < 10 && host_q.size() != 0; i++)
            tick(1, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 1);
        tick(0, 0, 0, 1, 0);
        send(8'h07);

        for (int c = 0; c < 4000; c++) begin
            if (host_q.size() == 0 && $urandom_range(0, 2) == 0)
                rand_cmd();
            tick($urandom_range(0, 4) != 0,
                 $urandom_range(0, 2) == 0,
                 32'h10 + 32'(4 * $urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 399) == 0);
        end
        drain(1);
        tick(0, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
